// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, function codes and sequencer state type
package alu_pkg;

  localparam int ALU_WIDTH      = 8;
  localparam int ALU_FUNC_WIDTH = 5;

  typedef logic [ALU_FUNC_WIDTH-1:0] alu_func_t;

  // Function codes seen by both the sequencer and the ALU; 0 and 23..31 are illegal.
  localparam alu_func_t F_INC   = 5'd1;
  localparam alu_func_t F_ADD   = 5'd2;
  localparam alu_func_t F_SUB   = 5'd3;
  localparam alu_func_t F_MUL   = 5'd4;
  localparam alu_func_t F_DIV   = 5'd5;
  localparam alu_func_t F_MOD   = 5'd6;
  localparam alu_func_t F_ADC   = 5'd7;
  localparam alu_func_t F_SBC   = 5'd8;
  localparam alu_func_t F_AND   = 5'd9;
  localparam alu_func_t F_OR    = 5'd10;
  localparam alu_func_t F_XOR   = 5'd11;
  localparam alu_func_t F_NOT   = 5'd12;
  localparam alu_func_t F_SHL   = 5'd13;
  localparam alu_func_t F_SHR   = 5'd14;
  localparam alu_func_t F_ASR   = 5'd15;
  localparam alu_func_t F_ROL   = 5'd16;
  localparam alu_func_t F_ROR   = 5'd17;
  localparam alu_func_t F_DEC   = 5'd18;
  localparam alu_func_t F_NEG   = 5'd19;
  localparam alu_func_t F_PASSA = 5'd20;
  localparam alu_func_t F_PASSB = 5'd21;
  localparam alu_func_t F_CMP   = 5'd22;

  localparam alu_func_t F_FIRST = F_INC;
  localparam alu_func_t F_LAST  = F_CMP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request, ALU-facing and result signals of the alu_seq stage
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int FUNC_WIDTH = ALU_FUNC_WIDTH
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_a;
  logic [WIDTH-1:0]      in_b;
  logic                  in_ci;
  logic [FUNC_WIDTH-1:0] in_f;

  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic                  alu_ci;
  logic [FUNC_WIDTH-1:0] alu_f;
  logic [WIDTH-1:0]      alu_s;
  logic                  alu_co;

  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_s;
  logic                  out_co;
  logic                  out_z;
  logic                  out_n;
  logic                  out_err;

  // Parent side: issues requests, hosts the ALU, consumes results.
  modport master (
    output in_valid, in_a, in_b, in_ci, in_f, alu_s, alu_co, out_ready,
    input  in_ready, alu_a, alu_b, alu_ci, alu_f,
    input  out_valid, out_s, out_co, out_z, out_n, out_err
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_ci, in_f, alu_s, alu_co, out_ready,
    output in_ready, alu_a, alu_b, alu_ci, alu_f,
    output out_valid, out_s, out_co, out_z, out_n, out_err
  );

endinterface

// File: rtl/alu_op_classify.sv
// rtl/alu_op_classify.sv - decodes legality, settle class and divide-by-zero (ALU_SEQ_DIVZERO_EN) of a request
module alu_op_classify
  import alu_pkg::*;
#(
  parameter int FUNC_WIDTH = ALU_FUNC_WIDTH
`ifdef ALU_SEQ_DIVZERO_EN
  ,
  parameter int WIDTH      = ALU_WIDTH
`endif
) (
  input  logic [FUNC_WIDTH-1:0] i_f,
`ifdef ALU_SEQ_DIVZERO_EN
  input  logic [WIDTH-1:0]      i_b,
`endif
  output logic                  o_legal,
  output logic                  o_long,
  output logic                  o_divzero
);

  logic w_is_div;

  assign w_is_div = (i_f == FUNC_WIDTH'(F_DIV)) || (i_f == FUNC_WIDTH'(F_MOD));
  assign o_legal  = (i_f >= FUNC_WIDTH'(F_FIRST)) && (i_f <= FUNC_WIDTH'(F_LAST));
  assign o_long   = (i_f == FUNC_WIDTH'(F_MUL)) || w_is_div;

`ifdef ALU_SEQ_DIVZERO_EN
  // Divide and modulo by zero are trapped before they reach the ALU.
  assign o_divzero = w_is_div && (i_b == '0);
`else
  // Without the trap every legal divide goes to the ALU unchanged.
  assign o_divzero = 1'b0;
`endif

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - stages operands onto the ALU, waits its settle time, holds the result (ALU_SEQ_DIVZERO_EN traps div/mod by 0)
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH       = ALU_WIDTH,
  parameter int FUNC_WIDTH  = ALU_FUNC_WIDTH,
  parameter int BASE_CYCLES = 1,
  parameter int LONG_CYCLES = 4
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int MAX_CYCLES = (BASE_CYCLES > LONG_CYCLES) ? BASE_CYCLES : LONG_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(BASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_CYCLES - 1);

  seq_state_t            r_state;
  seq_state_t            w_next;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic                  r_ci;
  logic [FUNC_WIDTH-1:0] r_f;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_s;
  logic                  r_co;
  logic                  r_err;

  logic w_legal;
  logic w_long;
  logic w_divzero;
  logic w_accept;
  logic w_reject;
  logic w_capture;

  alu_op_classify #(
    .FUNC_WIDTH (FUNC_WIDTH)
`ifdef ALU_SEQ_DIVZERO_EN
    ,
    .WIDTH      (WIDTH)
`endif
  ) u_classify (
    .i_f       (bus.in_f),
`ifdef ALU_SEQ_DIVZERO_EN
    .i_b       (bus.in_b),
`endif
    .o_legal   (w_legal),
    .o_long    (w_long),
    .o_divzero (w_divzero)
  );

  // state register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state plus the one-cycle accept/reject/capture strobes
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (w_legal && !w_divzero) begin
            w_accept = 1'b1;
            w_next   = EXEC;
          end else begin
            w_reject = 1'b1;
            w_next   = DONE;
          end
        end
      end
      EXEC: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // operand staging, settle countdown and result/flag capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_ci  <= 1'b0;
      r_f   <= '0;
      r_cnt <= '0;
      r_s   <= '0;
      r_co  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= bus.in_a;
        r_b   <= bus.in_b;
        r_ci  <= bus.in_ci;
        r_f   <= bus.in_f;
        r_cnt <= w_long ? CNT_LONG : CNT_BASE;
      end else if ((r_state == EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // The ALU function returns to 0 as soon as the result is taken.
      if (w_capture) begin
        r_s   <= bus.alu_s;
        r_co  <= bus.alu_co;
        r_err <= 1'b0;
        r_f   <= '0;
      end
      // Rejected requests never touch the ALU-side registers.
      if (w_reject) begin
        r_s   <= w_divzero ? '1 : '0;
        r_co  <= 1'b0;
        r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = (r_state == DONE);
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.alu_ci    = r_ci;
  assign bus.alu_f     = r_f;
  assign bus.out_s     = r_s;
  assign bus.out_co    = r_co;
  assign bus.out_err   = r_err;
  assign bus.out_z     = (r_s == '0);
  assign bus.out_n     = r_s[WIDTH-1];

endmodule

// File: doc/alu_seq.md
# alu_seq

Operand-staging and sequencing stage that sits directly upstream of the combinational ALU. It accepts one operation per valid/ready handshake and registers the operands and function code onto the ALU inputs. It holds them for a function-dependent number of settle cycles, then captures the ALU result and carry-out with derived flags into an output register. That register is presented downstream through a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8: operand/result width; matches ALU datapath width.
- FUNC_WIDTH, 5: function-code width.
- BASE_CYCLES, 1: settle cycles for short functions; must be ≥1.
- LONG_CYCLES, 4: settle cycles for mul (4), div (5), mod (6); must be ≥1.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  stage can accept.
- in_a, in_b  in  WIDTH  operands.
- in_ci  in  1  carry-in.
- in_f  in  FUNC_WIDTH  function code.
- alu_a, alu_b  out  WIDTH  registered operands to ALU.
- alu_ci  out  1  registered carry-in to ALU.
- alu_f  out  FUNC_WIDTH  registered function to ALU.
- alu_s  in  WIDTH  ALU result.
- alu_co  in  1  ALU carry-out.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_s  out  WIDTH  captured result.
- out_co  out  1  captured carry-out.
- out_z  out  1  out_s == 0.
- out_n  out  1  out_s[WIDTH-1].
- out_err  out  1  operation rejected/faulted.

## Operation
- States: IDLE, EXEC, DONE.
- Legal function codes: 1..22. Codes 0 and 23..31 are illegal.
- Long class: codes 4, 5, 6. All other legal codes are short.
- IDLE:
  - in_ready=1, out_valid=0, alu_f driven 0.
  - On in_valid with a legal code: latch a, b, ci and f. Load cnt = N-1, where N is LONG_CYCLES or BASE_CYCLES. Go to EXEC.
  - On in_valid with an illegal code: out_s=0, out_co=0, out_err=1. Go to DONE. The ALU is not driven.
- EXEC:
  - in_ready=0. alu_* carry the latched values.
  - If cnt==0: capture alu_s→out_s and alu_co→out_co, set out_err=0, go to DONE. Otherwise decrement cnt.
- DONE:
  - out_valid=1. Outputs are stable until the handshake completes. alu_f driven 0.
  - On out_ready: go to IDLE.
  - in_ready=0 in DONE. A simultaneous in_valid is ignored and must be re-presented.
- out_z and out_n derive combinationally from the out_s register. They are meaningful only while out_valid=1.
- Width rules:
  - The ALU result is taken at WIDTH bits. Overflow is reported only through alu_co.
  - The counter is $clog2(max(BASE_CYCLES,LONG_CYCLES)+1) bits wide.

## Timing
- Reset asserted, asynchronously:
  - State goes to IDLE. in_ready=1 once reset is released.
  - All registered outputs go to 0: alu_a, alu_b, alu_ci, alu_f, out_s, out_co, out_err, out_valid.
- Reset mid-EXEC or mid-DONE aborts the operation. No result is emitted.
- Latency, legal op accepted at edge t:
  - EXEC occupies cycles t..t+N-1.
  - The capture edge is t+N. out_valid is high from t+N.
- Latency, illegal op accepted at edge t: out_valid is high from t+1.
- Throughput: one operation per N+2 cycles at best, since IDLE and DONE each take one cycle.
- alu_* change only at the accept edge and at the edge leaving EXEC. The ALU sees stable inputs for N full cycles.

## Configuration
- Macro: ALU_SEQ_DIVZERO_EN.
- Defined: div (5) or mod (6) with in_b==0 is not issued. The stage goes IDLE→DONE directly with out_s = all ones, out_co=0, out_err=1, using illegal-op timing.
- Undefined: such operations are issued normally, and the ALU result is captured as-is with out_err=0.

## Structure
- Shared package alu_pkg holds:
  - ALU_WIDTH, ALU_FUNC_WIDTH.
  - Named localparams for all function codes 1..22.
  - The state enum (IDLE/EXEC/DONE).
  - The ALU itself should reference the same codes.
- One sub-module is natural: alu_op_classify, combinational. It takes f (and b when ALU_SEQ_DIVZERO_EN is defined) and produces legal, long and divzero.
- The ALU is instantiated by the parent, not inside alu_seq.

## Test plan
- Reset: assert rst mid-EXEC of a mul → all outputs 0 immediately and in_ready=1 after release; no out_valid follows.
- Add, a=8'hF0, b=8'h20, f=2, BASE_CYCLES=1 → out_valid at accept+1 edge; out_s=8'h10, out_co from ALU, out_z=0, out_n=0.
- Mul, f=4, LONG_CYCLES=4 → alu_* stable for exactly 4 cycles; out_valid at accept+4; in_ready=0 throughout.
- Illegal code f=0 and f=25 → out_valid one cycle after accept, out_err=1, out_s=0; alu_f stays 0.
- Div, a=8'h07, b=0, f=5 → with macro: out_s=8'hFF, out_err=1 after 1 cycle. Without macro: issued for LONG_CYCLES and out_err=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 → outputs stable, in_ready=0, and the second op is accepted only after the out handshake, in IDLE.
